// File: rtl/seq_counter_time_pkg.sv
// ---------------------------------------------------------------------------
// seq_counter_time_pkg
// Shared definitions for the basic computer's timing chain. The timing
// decoder imports the same defaults so the sequence-count width and the last
// legal T-state cannot drift apart between the counter and the decoder.
//   SC_WIDTH_DEF : default width of the sequence count (decoder input width)
//   MAX_T_DEF    : default last legal count value before a wrap is flagged
//   SC_T0        : count value that selects T0
//   run_state_t  : run-control state encoding (2'd3 is illegal, recovers
//                  to ST_IDLE)
// ---------------------------------------------------------------------------
package seq_counter_time_pkg;

  localparam int SC_WIDTH_DEF = 4;
  localparam int MAX_T_DEF    = 15;
  localparam int SC_T0        = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2
  } run_state_t;

endpackage

// File: rtl/seq_counter_time_sc_run_fsm.sv
// ---------------------------------------------------------------------------
// seq_counter_time_sc_run_fsm
// Run-control state machine: holds the state register, the S (start/stop)
// flip-flop and the single-step gating. The sequence count itself lives in
// the top; this block only tells it which state we are in and which control
// pulses were actually accepted.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : pulse, leaves IDLE
//   halt            : HLT, returns to IDLE from RUN or STEP_WAIT
//   sc_clr          : end-of-instruction clear
//   step_mode       : 1 = stop in STEP_WAIT after every instruction
//   step_req        : pulse, releases the next instruction in step mode
//   state           : registered run-control state
//   running         : registered S flip-flop (1 in RUN and STEP_WAIT)
//   start_acc       : start accepted this cycle (IDLE and start)
//   clr_acc         : sc_clr accepted this cycle (RUN, no halt)
// ---------------------------------------------------------------------------
module seq_counter_time_sc_run_fsm
  import seq_counter_time_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt,
  input  logic       sc_clr,
  input  logic       step_mode,
  input  logic       step_req,
  output run_state_t state,
  output logic       running,
  output logic       start_acc,
  output logic       clr_acc
);

  run_state_t next_state;

  // Accepted-event strobes. halt outranks sc_clr in RUN, and nothing but
  // start is looked at while IDLE.
  assign start_acc = (state == ST_IDLE) && start;
  assign clr_acc   = (state == ST_RUN) && !halt && sc_clr;

  // Next-state selection. step_mode is only consulted on leaving IDLE and at
  // an accepted clear, so a mode change mid-instruction takes effect at the
  // next instruction boundary. A step_req while step_mode is low is ignored.
  // The unused encoding falls through to IDLE.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = step_mode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          next_state = ST_IDLE;
        end else if (sc_clr) begin
          next_state = step_mode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_STEP_WAIT: begin
        if (halt) begin
          next_state = ST_IDLE;
        end else if (step_req && step_mode) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_STEP_WAIT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register and S flip-flop. S is registered from the next state so
  // it is exactly 1 whenever the machine sits in RUN or STEP_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: rtl/seq_counter_time.sv
// ---------------------------------------------------------------------------
// seq_counter_time
// Sequence counter (SC) and run control for the basic computer's timing
// chain. SC feeds the 4-to-16 timing decoder that produces T0..T15.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : pulse, sets S and leaves IDLE (also clears wrap_err)
//   halt        : HLT, clears S and SC
//   sc_clr      : CLR SC at the end of an instruction
//   step_mode   : 1 = one instruction per step_req
//   step_req    : pulse, releases the next instruction in step mode
//   sc_out      : current sequence count
//   running     : S flip-flop
//   instr_done  : one-cycle pulse the cycle after an accepted sc_clr
//   wrap_err    : sticky, SC passed MAX_T without being cleared
//   instr_cnt   : retired-instruction count, wraps silently
// ---------------------------------------------------------------------------
module seq_counter_time
  import seq_counter_time_pkg::*;
#(
  parameter int SC_WIDTH  = SC_WIDTH_DEF,
  parameter int MAX_T     = MAX_T_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 sc_clr,
  input  logic                 step_mode,
  input  logic                 step_req,
  output logic [SC_WIDTH-1:0]  sc_out,
  output logic                 running,
  output logic                 instr_done,
  output logic                 wrap_err,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  run_state_t state;
  logic       start_acc;
  logic       clr_acc;
  logic       at_max;

  seq_counter_time_sc_run_fsm u_run_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .sc_clr    (sc_clr),
    .step_mode (step_mode),
    .step_req  (step_req),
    .state     (state),
    .running   (running),
    .start_acc (start_acc),
    .clr_acc   (clr_acc)
  );

  assign at_max = (sc_out == SC_WIDTH'(MAX_T));

  // Sequence counter. It only moves in RUN; IDLE and STEP_WAIT hold it at T0
  // so that leaving either state always begins an instruction at T0. An
  // increment from MAX_T wraps to T0 (the wrap itself is flagged below).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_out <= SC_WIDTH'(SC_T0);
    end else if (state == ST_RUN) begin
      if (halt || sc_clr || at_max) begin
        sc_out <= SC_WIDTH'(SC_T0);
      end else begin
        sc_out <= sc_out + SC_WIDTH'(1);
      end
    end else begin
      sc_out <= SC_WIDTH'(SC_T0);
    end
  end

  // Instruction retirement: one registered pulse and one count per accepted
  // clear. A clear that loses to halt is not an accepted clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_done <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      instr_done <= clr_acc;
      if (clr_acc) begin
        instr_cnt <= instr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky wrap error: set when RUN would advance past MAX_T with no halt or
  // clear pending, cleared only by a fresh start out of IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_err <= 1'b0;
    end else if (start_acc) begin
      wrap_err <= 1'b0;
    end else if ((state == ST_RUN) && !halt && !sc_clr && at_max) begin
      wrap_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_counter_time.sv
// ---------------------------------------------------------------------------
// tb_seq_counter_time
// Self-checking bench for seq_counter_time. A behavioural reference model
// (plain integers for mode, count and flags) is advanced on every rising
// edge from the inputs that edge sampled; every output is then compared
// against it one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_seq_counter_time;

  localparam int SCW  = 4;
  localparam int MAXT = 15;
  localparam int CNTW = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic            halt;
  logic            sc_clr;
  logic            step_mode;
  logic            step_req;
  logic [SCW-1:0]  sc_out;
  logic            running;
  logic            instr_done;
  logic            wrap_err;
  logic [CNTW-1:0] instr_cnt;

  int vectors;
  int miscompares;

  // Reference model: m_mode 0 = stopped, 1 = executing, 2 = waiting for step
  int m_mode;
  int m_sc;
  int m_done;
  int m_wrap;
  int m_cnt;

  seq_counter_time #(
    .SC_WIDTH  (SCW),
    .MAX_T     (MAXT),
    .CNT_WIDTH (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt       (halt),
    .sc_clr     (sc_clr),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .sc_out     (sc_out),
    .running    (running),
    .instr_done (instr_done),
    .wrap_err   (wrap_err),
    .instr_cnt  (instr_cnt)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return the model to its power-on values
  task automatic resetModel();
    m_mode = 0;
    m_sc   = 0;
    m_done = 0;
    m_wrap = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge
  task automatic modelStep();
    if (rst) begin
      resetModel();
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (start) begin
          m_wrap = 0;
          m_mode = step_mode ? 2 : 1;
        end
        m_sc = 0;
      end else if (m_mode == 1) begin
        if (halt) begin
          m_mode = 0;
          m_sc   = 0;
        end else if (sc_clr) begin
          m_sc   = 0;
          m_done = 1;
          m_cnt  = (m_cnt + 1) % (1 << CNTW);
          m_mode = step_mode ? 2 : 1;
        end else if (m_sc == MAXT) begin
          m_sc   = 0;
          m_wrap = 1;
        end else begin
          m_sc = m_sc + 1;
        end
      end else begin
        if (halt) m_mode = 0;
        else if (step_req && step_mode) m_mode = 1;
        m_sc = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past edge
  task automatic applyStimulus(input logic s, input logic h, input logic c,
                               input logic m, input logic r);
    start     = s;
    halt      = h;
    sc_clr    = c;
    step_mode = m;
    step_req  = r;
    @(posedge clk);
    modelStep();
    #1;
    start    = 1'b0;
    halt     = 1'b0;
    sc_clr   = 1'b0;
    step_req = 1'b0;
  endtask

  // Compare every output against the model
  task automatic checkOutput(input string tag);
    vectors++;
    assert (sc_out === SCW'(m_sc)) else begin
      miscompares++;
      $error("[TB] FAIL %s sc_out: observed %0d expected %0d", tag, sc_out, m_sc);
    end
    vectors++;
    assert (running === (m_mode != 0)) else begin
      miscompares++;
      $error("[TB] FAIL %s running: observed %0b expected %0b", tag, running, (m_mode != 0));
    end
    vectors++;
    assert (instr_done === 1'(m_done)) else begin
      miscompares++;
      $error("[TB] FAIL %s instr_done: observed %0b expected %0d", tag, instr_done, m_done);
    end
    vectors++;
    assert (wrap_err === 1'(m_wrap)) else begin
      miscompares++;
      $error("[TB] FAIL %s wrap_err: observed %0b expected %0d", tag, wrap_err, m_wrap);
    end
    vectors++;
    assert (instr_cnt === CNTW'(m_cnt)) else begin
      miscompares++;
      $error("[TB] FAIL %s instr_cnt: observed %0h expected %0h", tag, instr_cnt, m_cnt);
    end
  endtask

  // Directed scenarios followed by a randomized run and the counter rollover
  initial begin
    logic rs, rh, rc, rr;
    logic rmode;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    start     = 1'b0;
    halt      = 1'b0;
    sc_clr    = 1'b0;
    step_mode = 1'b0;
    step_req  = 1'b0;
    resetModel();
    #12;
    checkOutput("reset");
    rst = 1'b0;

    // Basic run: 0,1,2,3, clear at 3, then 0,1
    $display("[TB] basic run with clear at T3");
    applyStimulus(1, 0, 0, 0, 0); checkOutput("run_t0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0); checkOutput("run_adv");
    end
    applyStimulus(0, 0, 1, 0, 0); checkOutput("clr_at_t3");
    applyStimulus(0, 0, 0, 0, 0); checkOutput("after_clr");

    // Wrap past MAX_T, then halt and restart to clear the sticky flag
    $display("[TB] wrap without clear");
    applyStimulus(0, 0, 1, 0, 0); checkOutput("clr_before_wrap");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 0, 0, 0); checkOutput("wrap_run");
    end
    applyStimulus(0, 1, 0, 0, 0); checkOutput("halt_keeps_wrap");
    applyStimulus(0, 0, 1, 0, 1); checkOutput("idle_ignores");
    applyStimulus(1, 0, 0, 0, 0); checkOutput("start_clears_wrap");
    applyStimulus(1, 0, 0, 0, 0); checkOutput("start_while_running");

    // Step mode
    $display("[TB] single-step mode");
    applyStimulus(0, 1, 0, 0, 0); checkOutput("halt_to_idle");
    applyStimulus(1, 0, 0, 1, 0); checkOutput("start_step");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 1, 0); checkOutput("step_wait");
    end
    applyStimulus(0, 0, 0, 1, 1); checkOutput("step_req_t0");
    applyStimulus(0, 0, 0, 1, 0); checkOutput("step_t1");
    applyStimulus(0, 0, 0, 1, 0); checkOutput("step_t2");
    applyStimulus(0, 0, 1, 1, 0); checkOutput("step_clr");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0); checkOutput("step_hold");
    end
    applyStimulus(0, 0, 0, 1, 1); checkOutput("step_resume");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0); checkOutput("step_adv");
    end

    // Back to free run at the boundary, then halt and clear together at T5
    $display("[TB] halt and clear together");
    applyStimulus(0, 0, 1, 0, 0); checkOutput("mode_change_clr");
    applyStimulus(0, 0, 1, 0, 0); checkOutput("back_to_back_clr");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0); checkOutput("to_t5");
    end
    applyStimulus(0, 1, 1, 0, 0); checkOutput("halt_and_clr");
    applyStimulus(1, 1, 0, 0, 0); checkOutput("start_halt_idle");

    // Asynchronous reset between edges at T7
    $display("[TB] asynchronous reset at T7");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 0); checkOutput("to_t7");
    end
    #3;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("async_reset");
    applyStimulus(1, 1, 0, 0, 1); checkOutput("pulses_in_reset");
    applyStimulus(1, 0, 1, 1, 1); checkOutput("pulses_in_reset2");
    #3;
    rst = 1'b0;

    // Randomized run against the model
    $display("[TB] randomized run");
    applyStimulus(1, 0, 0, 0, 0); checkOutput("rand_start");
    rmode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 19) == 0);
      rh = ($urandom_range(0, 29) == 0);
      rc = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) rmode = ~rmode;
      applyStimulus(rs, rh, rc, rmode, rr);
      checkOutput("random");
    end

    // Retired-instruction counter rollover
    $display("[TB] instruction counter rollover");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0); checkOutput("cnt_start");
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
    end
    checkOutput("cnt_ffff");
    applyStimulus(0, 0, 1, 0, 0); checkOutput("cnt_rollover");
    applyStimulus(0, 0, 0, 0, 0); checkOutput("cnt_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_counter_time.md
Name: seq_counter_time

Overview:
- Sequence counter (SC) and run control for the basic computer's timing chain.
- Produces the 4-bit timing count that the downstream 4-to-16 timing decoder turns into T0..T15.
- Holds the start/stop flip-flop (S) and supports a single-instruction step mode.
- Flags control-logic bugs where SC wraps without being cleared, and counts retired instructions.

Parameters:
- SC_WIDTH, 4: width of the sequence count; must match the timing decoder input.
- MAX_T, 15: last legal count value. Incrementing from MAX_T wraps SC to 0 and sets wrap_err.
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse that sets S (leaves IDLE).
- halt  in  1: HLT from control logic; clears S and SC.
- sc_clr  in  1: end-of-instruction clear from control logic (CLR SC).
- step_mode  in  1: 1 = execute one instruction per step_req.
- step_req  in  1: one-cycle pulse releasing the next instruction in step mode.
- sc_out  out  SC_WIDTH: current sequence count; feeds the timing decoder.
- running  out  1: S flip-flop; 1 in RUN and STEP_WAIT.
- instr_done  out  1: one-cycle pulse, registered, asserted the cycle after sc_clr is accepted.
- wrap_err  out  1: sticky error; SC passed MAX_T without a clear.
- instr_cnt  out  CNT_WIDTH: number of accepted sc_clr events, wrapping modulo 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, active-high):
  - sc_out=0, running=0, instr_done=0, wrap_err=0, instr_cnt=0, state=IDLE.
  - Reset mid-instruction abandons the instruction immediately; no instr_done pulse is produced.
- States:
  - IDLE: running=0; SC held at 0.
  - RUN: running=1; SC advances.
  - STEP_WAIT: running=1; SC held at 0.
- IDLE transitions:
  - start=1 and step_mode=0 -> RUN.
  - start=1 and step_mode=1 -> STEP_WAIT.
  - start from IDLE also clears wrap_err.
  - halt, sc_clr and step_req are ignored in IDLE.
- RUN, evaluated each cycle in priority order:
  - halt: SC<=0, go to IDLE, no instr_done, instr_cnt unchanged.
  - Otherwise sc_clr: SC<=0, instr_done<=1 next cycle, instr_cnt+=1. Then go to STEP_WAIT if step_mode=1, else stay in RUN.
  - Otherwise, if SC==MAX_T: SC<=0 and wrap_err<=1, stay in RUN.
  - Otherwise: SC<=SC+1.
- STEP_WAIT:
  - halt -> IDLE.
  - Otherwise step_req -> RUN.
  - SC stays 0. In the cycle after step_req is accepted, sc_out=0 (T0) and RUN advances from there.
- Latency:
  - sc_out changes one clock after the controlling input is sampled.
  - sc_out=0 is presented for exactly one cycle per instruction in RUN (T0), plus every STEP_WAIT cycle.
- start while running: ignored, with no effect on SC or state.
- step_mode changes: sampled only when sc_clr is accepted, so a mode change mid-instruction takes effect at the instruction boundary. step_req with step_mode=0 is ignored.
- Simultaneous events:
  - halt+sc_clr in the same cycle: halt wins; no instr_done, no count.
  - start+halt in IDLE: start is taken (halt is ignored in IDLE).
- Arithmetic:
  - SC uses unsigned SC_WIDTH-bit addition; MAX_T < 2^SC_WIDTH is required.
  - instr_cnt wraps silently to 0.
- instr_done is a 1-cycle pulse and never stretches; back-to-back sc_clr gives back-to-back pulses.
- wrap_err clears only on reset or on start from IDLE.

Decomposition:
- Shared timing package holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, STEP_WAIT=2'd2, with 2'd3 illegal and recovering to IDLE.
  - Constant SC_T0 = 0.
  - Default SC_WIDTH/MAX_T, shared with the timing decoder so their widths cannot diverge.
- One sub-module is natural: sc_run_fsm (state register, S flip-flop, step gating). SC, instr_cnt and the flags stay in the top.

Test Plan:
- Reset then start=1 (step_mode=0), sc_clr at the cycle sc_out=3 -> sc_out sequence 0,1,2,3,0,1; instr_done high exactly one cycle after the clear; instr_cnt=1.
- Run with no sc_clr for 17 cycles -> sc_out runs 0..15 then 0; wrap_err=1 from the wrap cycle onward; a later start from IDLE clears it.
- step_mode=1, start, sc_clr at sc_out=2 -> running=1, sc_out holds 0 for 5 idle cycles; step_req -> sc_out 0,1,2... resumes; instr_cnt increments once per instruction.
- halt and sc_clr together at sc_out=5 -> next cycle sc_out=0, running=0, instr_done=0, instr_cnt unchanged; a further start returns to RUN.
- Assert rst asynchronously mid-clock at sc_out=7 -> all outputs 0 immediately, before the next edge; start/halt/step_req pulses during rst have no effect.
- Preload instr_cnt to 16'hFFFF via 65535 accepted sc_clr events, then one more sc_clr -> instr_cnt=0 with no other flag change.
